serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract sequencer. It time-multiplexes one instance of the single-bit add/subtract cell over a WIDTH-bit operand pair, LSB first, with a registered carry. It sits between a requesting FSM and the register file. It gives a start/busy/done handshake and returns result, carry-out and signed overflow.

---
 rtl/serial_addsub_pkg.sv | 33 +++
 rtl/serial_addsub_ctrl_cell.sv | 36 +++
 rtl/serial_addsub_ctrl.sv | 173 +++++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_pkg
//
// Shared definitions for the bit-serial add/subtract sequencer:
//   - sequencer state encoding (2 bits, 11 is illegal and recovers to IDLE)
//   - operation encoding for the op input / AS cell input
//   - small helper for the two's-complement overflow rule
//
// Imported by serial_addsub_ctrl and serial_addsub_ctrl_cell.
// ---------------------------------------------------------------------------
package serial_addsub_pkg;

    // Sequencer states. The encoding is fixed because other blocks decode
    // the state bits directly when debugging the register-file interface.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Operation select: add uses B as-is with carry-in 0, subtract inverts B
    // and seeds the carry with 1 (two's complement).
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow happens exactly when the carry into the MSB differs
    // from the carry out of the MSB.
    function automatic logic signed_ovf(input logic carry_into_msb,
                                        input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage : serial_addsub_pkg

// File: rtl/serial_addsub_ctrl_cell.sv
// ---------------------------------------------------------------------------
// serial_addsub_ctrl_cell
//
// Single-bit add/subtract cell. Purely combinational full adder whose B
// input is conditionally inverted by AS, so one instance handles both the
// add and the two's-complement subtract bit slices.
//
// Ports:
//   A    in   operand A bit
//   B    in   operand B bit (inverted internally when AS = OP_SUB)
//   cin  in   carry in
//   AS   in   0 = add, 1 = subtract
//   sum  out  sum bit
//   cout out  carry out
// ---------------------------------------------------------------------------
module serial_addsub_ctrl_cell
    import serial_addsub_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic cin,
    input  logic AS,
    output logic sum,
    output logic cout
);

    logic b_eff;

    // B is XORed with the subtract select so subtract becomes A + ~B + cin.
    always_comb begin
        b_eff = B ^ (AS == OP_SUB);
        sum   = A ^ b_eff ^ cin;
        cout  = (A & b_eff) | (cin & (A ^ b_eff));
    end

endmodule : serial_addsub_ctrl_cell

// File: rtl/serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_addsub_ctrl
//
// Bit-serial add/subtract sequencer. One single-bit add/subtract cell is
// reused over WIDTH clock cycles, LSB first, with the carry held in a
// register between bits. The requesting FSM sees a start/busy/done
// handshake; result, cout and ovf are held until the next accepted start
// completes (they are not cleared when a new operation begins).
//
// Timing: start sampled at edge 0 -> busy in cycles 1..WIDTH -> done pulse
// in cycle WIDTH+1 -> back in IDLE for cycle WIDTH+2.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CNT_W  bit-counter width, 2**CNT_W >= WIDTH
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request, only honoured in IDLE
//   op      in   0 = add, 1 = subtract (a - b), sampled with start
//   abort   in   (only with SERIAL_ADDSUB_ABORT_EN) cancel a running op
//   a, b    in   operands, sampled with start
//   busy    out  high while bits are being processed
//   done    out  one-cycle completion pulse
//   result  out  sum/difference
//   cout    out  final carry-out (for subtract: 1 = no borrow)
//   ovf     out  two's-complement overflow
//
// Optional feature macro: SERIAL_ADDSUB_ABORT_EN
//   When defined, the abort port exists and an abort seen in RUN returns
//   the sequencer to IDLE without a done pulse and without touching
//   result/cout/ovf. start takes priority over abort in IDLE (abort is
//   simply ignored there).
// ---------------------------------------------------------------------------
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
`ifdef SERIAL_ADDSUB_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-2:0]   res_sr;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               op_r;

    logic               cell_sum;
    logic               cell_cout;
    logic [WIDTH-1:0]   res_next;
    logic               last_bit;
    logic               abort_hit;

    // The shared cell always looks at the LSBs of the operand shift
    // registers and at the registered carry.
    serial_addsub_ctrl_cell u_cell (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .cin  (carry),
        .AS   (op_r),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // Partial result: the new sum bit enters at the MSB and everything
    // moves one place right. Only WIDTH-1 bits need storing between cycles
    // because the last sum bit arrives on the final edge and goes straight
    // into the held result. last_bit marks the edge that processes the MSB.
    always_comb begin
        res_next = {cell_sum, res_sr};
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // Abort only exists in the optional build; in the default build the
    // run phase can never be cut short.
`ifdef SERIAL_ADDSUB_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Single sequencer process: state, datapath registers and all outputs
    // are registered here. IDLE loads the operands and seeds the carry with
    // the op bit (1 for subtract gives the +1 of two's complement). RUN
    // processes one bit per edge; on the edge that handles the MSB it
    // publishes result/cout/ovf and moves to DONE. DONE raises done for one
    // cycle and always returns to IDLE, ignoring start. The unused encoding
    // 11 falls back to IDLE with the handshake outputs low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            op_r   <= OP_ADD;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        op_r  <= op;
                        carry <= op;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (abort_hit) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        a_sr   <= a_sr >> 1;
                        b_sr   <= b_sr >> 1;
                        res_sr <= res_next[WIDTH-1:1];
                        carry  <= cell_cout;
                        cnt    <= cnt + CNT_W'(1);
                        if (last_bit) begin
                            result <= res_next;
                            cout   <= cell_cout;
                            ovf    <= signed_ovf(carry, cell_cout);
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_ctrl
//
// Self-checking bench for serial_addsub_ctrl (WIDTH = 8). A table of
// directed add/subtract vectors with hand-computed result/cout/ovf is run
// through the full start/busy/done handshake, followed by hand-written
// sequences for start-while-busy/done, reset in the middle of RUN and,
// when SERIAL_ADDSUB_ABORT_EN is defined, the abort behaviour.
// ---------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op;
`ifdef SERIAL_ADDSUB_ABORT_EN
    logic             abort;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int errors;
    int checks;
    int cyc;

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    serial_addsub_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
`ifdef SERIAL_ADDSUB_ABORT_EN
        .abort  (abort),
`endif
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge; cyc counts cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present start with operands in the current cycle, release it after
    // the accepting edge (scrambling the operands, which must not matter),
    // then wait for done with a bounded cycle budget. Returns the number of
    // busy cycles seen and the cycle (relative to acceptance) of done.
    // Returns positioned in the done cycle.
    task automatic applyStimulus(input logic o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y,
                                 output int busy_cnt, output int done_cyc);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = y ^ 8'h5A;
        busy_cnt = 0;
        done_cyc = -1;
        for (int c = 1; c <= 3 * WIDTH; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cyc;
        int done_seen;
        int busy_seen;

        errors = 0;
        checks = 0;
        cyc    = 0;

        vecs[0] = '{op: 1'b0, a: 8'h35, b: 8'h4A, res: 8'h7F, co: 1'b0, ov: 1'b0};
        vecs[1] = '{op: 1'b1, a: 8'h10, b: 8'h01, res: 8'h0F, co: 1'b1, ov: 1'b0};
        vecs[2] = '{op: 1'b1, a: 8'h00, b: 8'h01, res: 8'hFF, co: 1'b0, ov: 1'b0};
        vecs[3] = '{op: 1'b0, a: 8'h7F, b: 8'h01, res: 8'h80, co: 1'b0, ov: 1'b1};
        vecs[4] = '{op: 1'b1, a: 8'h80, b: 8'h01, res: 8'h7F, co: 1'b1, ov: 1'b1};
        vecs[5] = '{op: 1'b0, a: 8'hFF, b: 8'h01, res: 8'h00, co: 1'b1, ov: 1'b0};
        vecs[6] = '{op: 1'b0, a: 8'h80, b: 8'h80, res: 8'h00, co: 1'b1, ov: 1'b1};
        vecs[7] = '{op: 1'b1, a: 8'h05, b: 8'h05, res: 8'h00, co: 1'b1, ov: 1'b0};
        vecs[8] = '{op: 1'b1, a: 8'h7F, b: 8'hFF, res: 8'h80, co: 1'b0, ov: 1'b1};
        vecs[9] = '{op: 1'b0, a: 8'hA5, b: 8'h5A, res: 8'hFF, co: 1'b0, ov: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDSUB_ABORT_EN
        abort = 1'b0;
`endif

        // Reset state.
        tick();
        tick();
        checkOutput("reset_busy",   32'(busy),   32'd0);
        checkOutput("reset_done",   32'(done),   32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_cout",   32'(cout),   32'd0);
        checkOutput("reset_ovf",    32'(ovf),    32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors through the full handshake.
        $display("[TB] running %0d table vectors", NVEC);
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, busy_cnt, done_cyc);
            checkOutput($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'(WIDTH));
            checkOutput($sformatf("v%0d_done_cycle", i),  32'(done_cyc), 32'(WIDTH + 1));
            checkOutput($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            checkOutput($sformatf("v%0d_cout", i),   32'(cout),   32'(vecs[i].co));
            checkOutput($sformatf("v%0d_ovf", i),    32'(ovf),    32'(vecs[i].ov));
            tick();
            checkOutput($sformatf("v%0d_done_low", i),    32'(done),   32'd0);
            checkOutput($sformatf("v%0d_result_held", i), 32'(result), 32'(vecs[i].res));
        end

        // start pulses in RUN (cycle 3) and DONE (cycle 9) are dropped.
        $display("[TB] start while busy/done");
        cyc   = 0;
        start = 1'b1;
        op    = 1'b0;
        a     = 8'h35;
        b     = 8'h4A;
        tick();
        done_seen = 0;
        for (int c = 1; c <= 9; c++) begin
            if (done) done_seen++;
            if (c == 9) begin
                checkOutput("ign_done_c9",   32'(done),   32'd1);
                checkOutput("ign_result_c9", 32'(result), 32'h7F);
            end
            if (c == 3 || c == 9) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 8'h00;
                b     = 8'h01;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        if (done) done_seen++;
        checkOutput("ign_cycle10_busy",   32'(busy),      32'd0);
        checkOutput("ign_cycle10_result", 32'(result),    32'h7F);
        checkOutput("ign_done_pulses",    32'(done_seen), 32'd1);
        // Start in cycle 10 is accepted.
        applyStimulus(1'b1, 8'h10, 8'h01, busy_cnt, done_cyc);
        checkOutput("ign_next_busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        checkOutput("ign_next_result",      32'(result),   32'h0F);
        checkOutput("ign_next_cout",        32'(cout),     32'd1);
        tick();

        // Reset in the middle of RUN.
        $display("[TB] reset during run");
        applyStimulus(1'b0, 8'h7F, 8'h01, busy_cnt, done_cyc);
        checkOutput("rst_pre_result", 32'(result), 32'h80);
        tick();
        cyc   = 0;
        start = 1'b1;
        op    = 1'b1;
        a     = 8'h80;
        b     = 8'h01;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("rst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",   32'(busy),   32'd0);
        checkOutput("rst_done",   32'(done),   32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_cout",   32'(cout),   32'd0);
        checkOutput("rst_ovf",    32'(ovf),    32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            tick();
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        checkOutput("rst_no_done", 32'(done_seen), 32'd0);
        checkOutput("rst_no_busy", 32'(busy_seen), 32'd0);
        applyStimulus(1'b0, 8'h35, 8'h4A, busy_cnt, done_cyc);
        checkOutput("rst_after_done_cycle", 32'(done_cyc), 32'(WIDTH + 1));
        checkOutput("rst_after_result",     32'(result),   32'h7F);
        checkOutput("rst_after_ovf",        32'(ovf),      32'd0);
        tick();

`ifdef SERIAL_ADDSUB_ABORT_EN
        // Abort in cycle 5 of RUN: IDLE in cycle 6, no done, old result kept.
        $display("[TB] abort during run");
        cyc   = 0;
        start = 1'b1;
        op    = 1'b1;
        a     = 8'h00;
        b     = 8'h01;
        tick();
        start = 1'b0;
        while (cyc < 5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy_c6", 32'(busy), 32'd0);
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            if (done) done_seen++;
            if (busy) busy_seen++;
            tick();
        end
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);
        checkOutput("abort_no_busy", 32'(busy_seen), 32'd0);
        checkOutput("abort_result",  32'(result),    32'h7F);
        checkOutput("abort_cout",    32'(cout),      32'd0);
        checkOutput("abort_ovf",     32'(ovf),       32'd0);

        // start and abort together in IDLE: the operation starts.
        start = 1'b1;
        abort = 1'b1;
        op    = 1'b0;
        a     = 8'h7F;
        b     = 8'h01;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_busy", 32'(busy), 32'd1);
        done_cyc = -1;
        for (int c = 1; c <= 3 * WIDTH; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        checkOutput("abort_start_done_cycle", 32'(done_cyc), 32'(WIDTH + 1));
        checkOutput("abort_start_result",     32'(result),   32'h80);
        checkOutput("abort_start_ovf",        32'(ovf),      32'd1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_addsub_ctrl
